// File: rtl/mips_decode_execute.sv
// Decode/execute slice of a 5-stage MIPS pipeline.
// Stage 1 decodes the instruction into ID/EX; stage 2 runs the ALU into EX/MEM.
module mips_decode_execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] ex_alu_result,
  output logic        ex_zero,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest_reg,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_branch_taken,
  output logic [31:0] ex_branch_target
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluBad = 4'b1111;

  // Stage 1: main control decode
  logic       w_reg_dst, w_alu_src, w_mem_to_reg, w_reg_write;
  logic       w_mem_read, w_mem_write, w_branch;
  logic [1:0] w_alu_op;
  logic       w_unused_rs_idx;

  assign w_unused_rs_idx = ^instr[25:21];

  always_comb begin
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 2'b00;
    if (instr_valid) begin
      case (instr[31:26])
        OpRType: begin
          w_reg_dst   = 1'b1;
          w_reg_write = 1'b1;
          w_alu_op    = 2'b10;
        end
        OpLw: begin
          w_alu_src    = 1'b1;
          w_mem_to_reg = 1'b1;
          w_reg_write  = 1'b1;
          w_mem_read   = 1'b1;
        end
        OpSw: begin
          w_alu_src   = 1'b1;
          w_mem_write = 1'b1;
        end
        OpBeq: begin
          w_branch = 1'b1;
          w_alu_op = 2'b01;
        end
        OpAddi: begin
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ID/EX register
  logic        r_reg_dst, r_alu_src, r_mem_to_reg, r_reg_write;
  logic        r_mem_read, r_mem_write, r_branch;
  logic [1:0]  r_alu_op;
  logic [5:0]  r_funct;
  logic [4:0]  r_rt, r_rd;
  logic [31:0] r_imm_sext, r_pc, r_rs_data, r_rt_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_alu_op     <= 2'b00;
      r_funct      <= 6'd0;
      r_rt         <= 5'd0;
      r_rd         <= 5'd0;
      r_imm_sext   <= 32'd0;
      r_pc         <= 32'd0;
      r_rs_data    <= 32'd0;
      r_rt_data    <= 32'd0;
    end else begin
      r_reg_dst    <= w_reg_dst;
      r_alu_src    <= w_alu_src;
      r_mem_to_reg <= w_mem_to_reg;
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_alu_op     <= w_alu_op;
      r_funct      <= instr[5:0];
      r_rt         <= instr[20:16];
      r_rd         <= instr[15:11];
      r_imm_sext   <= {{16{instr[15]}}, instr[15:0]};
      r_pc         <= pc;
      r_rs_data    <= rs_data;
      r_rt_data    <= rt_data;
    end
  end

  // Stage 2: ALU control and ALU
  logic [3:0]  w_alu_ctl;
  logic [31:0] w_alu_b, w_alu_result, w_branch_target;
  logic [4:0]  w_dest_reg;

  always_comb begin
    w_alu_ctl = AluAdd;
    case (r_alu_op)
      2'b01: w_alu_ctl = AluSub;
      2'b10: begin
        case (r_funct)
          6'b100000: w_alu_ctl = AluAdd;
          6'b100010: w_alu_ctl = AluSub;
          6'b100100: w_alu_ctl = AluAnd;
          6'b100101: w_alu_ctl = AluOr;
          6'b101010: w_alu_ctl = AluSlt;
          6'b100111: w_alu_ctl = AluNor;
          default:   w_alu_ctl = AluBad;
        endcase
      end
      default: w_alu_ctl = AluAdd;
    endcase
  end

  assign w_alu_b = r_alu_src ? r_imm_sext : r_rt_data;

  always_comb begin
    w_alu_result = 32'd0;
    case (w_alu_ctl)
      AluAdd: w_alu_result = r_rs_data + w_alu_b;
      AluSub: w_alu_result = r_rs_data - w_alu_b;
      AluAnd: w_alu_result = r_rs_data & w_alu_b;
      AluOr:  w_alu_result = r_rs_data | w_alu_b;
      AluSlt: w_alu_result = {31'd0, $signed(r_rs_data) < $signed(w_alu_b)};
      AluNor: w_alu_result = ~(r_rs_data | w_alu_b);
      default: w_alu_result = 32'd0;
    endcase
  end

  assign w_dest_reg      = r_reg_dst ? r_rd : r_rt;
  assign w_branch_target = r_pc + 32'd4 + {r_imm_sext[29:0], 2'b00};

  // EX/MEM register
  logic [31:0] r_ex_alu_result, r_ex_store_data, r_ex_branch_target;
  logic        r_ex_zero, r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;
  logic        r_ex_mem_to_reg, r_ex_branch_taken;
  logic [4:0]  r_ex_dest_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_alu_result    <= 32'd0;
      r_ex_zero          <= 1'b0;
      r_ex_store_data    <= 32'd0;
      r_ex_dest_reg      <= 5'd0;
      r_ex_reg_write     <= 1'b0;
      r_ex_mem_read      <= 1'b0;
      r_ex_mem_write     <= 1'b0;
      r_ex_mem_to_reg    <= 1'b0;
      r_ex_branch_taken  <= 1'b0;
      r_ex_branch_target <= 32'd0;
    end else begin
      r_ex_alu_result    <= w_alu_result;
      r_ex_zero          <= (w_alu_result == 32'd0);
      r_ex_store_data    <= r_rt_data;
      r_ex_dest_reg      <= w_dest_reg;
      r_ex_reg_write     <= r_reg_write;
      r_ex_mem_read      <= r_mem_read;
      r_ex_mem_write     <= r_mem_write;
      r_ex_mem_to_reg    <= r_mem_to_reg;
      r_ex_branch_taken  <= r_branch && (w_alu_result == 32'd0);
      r_ex_branch_target <= w_branch_target;
    end
  end

  assign ex_alu_result    = r_ex_alu_result;
  assign ex_zero          = r_ex_zero;
  assign ex_store_data    = r_ex_store_data;
  assign ex_dest_reg      = r_ex_dest_reg;
  assign ex_reg_write     = r_ex_reg_write;
  assign ex_mem_read      = r_ex_mem_read;
  assign ex_mem_write     = r_ex_mem_write;
  assign ex_mem_to_reg    = r_ex_mem_to_reg;
  assign ex_branch_taken  = r_ex_branch_taken;
  assign ex_branch_target = r_ex_branch_target;

endmodule

// File: tb/tb_mips_decode_execute.sv
// Scoreboard bench for mips_decode_execute: directed vectors queue expectations,
// a monitor pops and compares two edges after each instruction is sampled.
module tb_mips_decode_execute;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [31:0] ex_alu_result, ex_store_data, ex_branch_target;
  logic        ex_zero, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch_taken;
  logic [4:0]  ex_dest_reg;

  mips_decode_execute dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .pc               (pc),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .ex_alu_result    (ex_alu_result),
    .ex_zero          (ex_zero),
    .ex_store_data    (ex_store_data),
    .ex_dest_reg      (ex_dest_reg),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .ex_mem_to_reg    (ex_mem_to_reg),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] alu;
    logic        zero;
    logic [31:0] st;
    logic [4:0]  dest;
    logic [4:0]  ctl;  // {reg_write, mem_read, mem_write, mem_to_reg, branch_taken}
    logic [31:0] tgt;
    logic        ctl_only;
    int          due;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tgt_of(input logic [31:0] p, input logic [31:0] ins);
    logic [31:0] s;
    s = {{16{ins[15]}}, ins[15:0]};
    return p + 32'd4 + (s << 2);
  endfunction

  task automatic issue(input string tag, input logic v, input logic [31:0] ins,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] alu, input logic zero, input logic [4:0] dest,
                       input logic [4:0] ctl, input logic ctl_only);
    exp_t e;
    @(negedge clk);
    instr_valid = v;
    instr       = ins;
    pc          = p;
    rs_data     = a;
    rt_data     = b;
    e.tag = tag; e.alu = alu; e.zero = zero; e.st = b; e.dest = dest; e.ctl = ctl;
    e.tgt = tgt_of(p, ins); e.ctl_only = ctl_only; e.due = edge_cnt + 2;
    q.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " alu"}, ex_alu_result, 32'd0);
    chk({nm, " store"}, ex_store_data, 32'd0);
    chk({nm, " target"}, ex_branch_target, 32'd0);
    chk({nm, " ctl"}, {20'd0, ex_dest_reg, ex_zero, ex_reg_write, ex_mem_read, ex_mem_write,
                       ex_mem_to_reg, ex_branch_taken}, 32'd0);
  endtask

  // Monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0 && q[0].due < edge_cnt) begin
      e = q.pop_front();
      chk({e.tag, " missed slot"}, 32'(edge_cnt), 32'(e.due));
    end
    if (q.size() > 0 && q[0].due == edge_cnt) begin
      e = q.pop_front();
      chk({e.tag, " ctl"}, {27'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                            ex_branch_taken}, {27'd0, e.ctl});
      if (!e.ctl_only) begin
        chk({e.tag, " alu"}, ex_alu_result, e.alu);
        chk({e.tag, " zero"}, {31'd0, ex_zero}, {31'd0, e.zero});
        chk({e.tag, " store"}, ex_store_data, e.st);
        chk({e.tag, " dest"}, {27'd0, ex_dest_reg}, {27'd0, e.dest});
        chk({e.tag, " target"}, ex_branch_target, e.tgt);
      end
    end
  end

  initial begin
    instr_valid = 1'b1;
    instr       = 32'h0022_1820;
    rs_data     = 32'd5;
    rt_data     = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset held");
    rst_n = 1'b1;

    //     tag      v   instr         pc        rs            rt            alu           z  dst ctl       co
    issue("add",  1, 32'h0022_1820, 32'h0,  32'd5,        32'd7,        32'd12,       0, 3, 5'b10000, 0);
    issue("sub",  1, 32'h0022_1822, 32'h0,  32'd5,        32'd7,        32'hFFFF_FFFE, 0, 3, 5'b10000, 0);
    issue("and",  1, 32'h0022_1824, 32'h0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0, 3, 5'b10000, 0);
    issue("or",   1, 32'h0022_1825, 32'h0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0, 3, 5'b10000, 0);
    issue("nor",  1, 32'h0022_1827, 32'h0,  32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_000F, 0, 3, 5'b10000, 0);
    issue("slt1", 1, 32'h0022_182A, 32'h0,  32'hFFFF_FFFF, 32'd1,        32'd1,        0, 3, 5'b10000, 0);
    issue("slt0", 1, 32'h0022_182A, 32'h0,  32'd1,        32'hFFFF_FFFF, 32'd0,        1, 3, 5'b10000, 0);
    issue("lw",   1, 32'h8C43_0004, 32'h8,  32'h100,      32'd0,        32'h104,      0, 3, 5'b11010, 0);
    issue("sw",   1, 32'hAC43_FFFC, 32'hC,  32'h100,      32'hDEAD,     32'hFC,       0, 3, 5'b00100, 0);
    issue("beqT", 1, 32'h1022_0003, 32'h40, 32'd9,        32'd9,        32'd0,        1, 2, 5'b00001, 0);
    issue("beqN", 1, 32'h1022_0003, 32'h40, 32'd9,        32'd8,        32'd1,        0, 2, 5'b00000, 0);
    issue("ill",  1, 32'hFC00_0000, 32'h44, 32'd3,        32'd4,        32'd0,        0, 0, 5'b00000, 1);
    issue("addi", 1, 32'h2024_0001, 32'h48, 32'hFFFF_FFFF, 32'd0,        32'd0,        1, 4, 5'b10000, 0);
    issue("bub",  0, 32'h0022_1820, 32'h4C, 32'd5,        32'd7,        32'd0,        0, 0, 5'b00000, 1);
    issue("badf", 1, 32'h0022_1800, 32'h50, 32'd5,        32'd7,        32'd0,        1, 3, 5'b10000, 0);

    @(negedge clk);
    instr_valid = 1'b1;
    instr       = 32'h0022_1820;
    rs_data     = 32'd5;
    rt_data     = 32'd7;
    repeat (4) @(negedge clk);
    chk("queue drained", 32'(q.size()), 32'd0);
    chk("pre-reset reg_write", {31'd0, ex_reg_write}, 32'd1);

    // Asynchronous reset between edges while valid instructions keep streaming
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("async reset");
    repeat (2) @(posedge clk);
    #1 chk_zero("reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    issue("post", 1, 32'h0022_1820, 32'h0, 32'd5, 32'd7, 32'd12, 0, 3, 5'b10000, 0);
    repeat (4) @(negedge clk);
    chk("final drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
